// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions used by the fetch stage: bubble word, J-format
// field positions, IF/ID record and next-PC source selector.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // J-format instruction layout
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 26;
  localparam int unsigned JTGT_MSB = 25;
  localparam int unsigned JTGT_LSB = 0;
  localparam logic [5:0]  OPC_J    = 6'b000010;

  // IF/ID pipeline record
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  // Source of the next fetch PC
  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_BRANCH,
    NPC_JUMP
  } npc_sel_e;

  // Pseudo-direct jump target built from the IF/ID contents
  function automatic logic [31:0] jump_target(input ifid_t r);
    return {r.pcplus4[31:28], r.instr[JTGT_MSB:JTGT_LSB], 2'b00};
  endfunction

  // True when the word carries the J opcode
  function automatic logic is_jump_opcode(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB] == OPC_J;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC selection for the fetch stage.
module pc_next_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  ifid_t       ifid_i,
  input  logic        pcsrc_i,
  input  logic        jump_i,
  input  logic [31:0] pcbranch_i,
  input  logic        stall_i,
  input  logic        rdy_i,
  output logic [31:0] pc_d_o,
  output logic [31:0] pcplus4_o,
  output logic        redirect_o
);

  npc_sel_e    sel;
  logic        redirect;
  logic [31:0] pcplus4;

  assign pcplus4    = pc_i + 32'd4;
  assign redirect   = (pcsrc_i | jump_i) & ifid_i.valid & ~stall_i;
  assign pcplus4_o  = pcplus4;
  assign redirect_o = redirect;

  // Pick the next-PC source; a branch beats a jump when both are raised
  always_comb begin
    sel = NPC_SEQ;
    if (redirect) begin
      sel = pcsrc_i ? NPC_BRANCH : NPC_JUMP;
    end else if (stall_i || !rdy_i) begin
      sel = NPC_HOLD;
    end
  end

  // Produce the next PC for the chosen source
  always_comb begin
    pc_d_o = pcplus4;
    unique case (sel)
      NPC_SEQ:    pc_d_o = pcplus4;
      NPC_HOLD:   pc_d_o = pc_i;
      NPC_BRANCH: pc_d_o = {pcbranch_i[31:2], 2'b00};
      NPC_JUMP:   pc_d_o = jump_target(ifid_i);
      default:    pc_d_o = pcplus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// saturating count of bubbles loaded into IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pcsrc_d,
  input  logic [31:0] pcbranch_d,
  input  logic        jump_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [15:0] bubble_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pcplus4_f;
  logic        redirect;
  ifid_t       ifid_q, ifid_d;
  logic        load_bubble;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};

  pc_next_sel u_pc_next_sel (
    .pc_i       (pc_q),
    .ifid_i     (ifid_q),
    .pcsrc_i    (pcsrc_d),
    .jump_i     (jump_d),
    .pcbranch_i (pcbranch_d),
    .stall_i    (stall_f),
    .rdy_i      (imem_rdy),
    .pc_d_o     (pc_d),
    .pcplus4_o  (pcplus4_f),
    .redirect_o (redirect)
  );

  // IF/ID next value: stall holds, redirect/flush/wait-state inserts a bubble
  always_comb begin
    ifid_d      = ifid_q;
    load_bubble = 1'b0;
    if (stall_f) begin
      ifid_d = ifid_q;
    end else if (redirect || flush_d || !imem_rdy) begin
      ifid_d      = IFID_BUBBLE;
      load_bubble = 1'b1;
    end else begin
      ifid_d = '{instr: imem_rdata, pcplus4: pcplus4_f, valid: 1'b1};
    end
  end

  // Saturating bubble counter
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      ifid_q       <= IFID_BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign instr_d    = ifid_q.instr;
  assign pcplus4_d  = ifid_q.pcplus4;
  assign valid_d    = ifid_q.valid;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, flush_d, pcsrc_d, jump_d, imem_rdy;
  logic [31:0] pcbranch_d;
  logic [31:0] imem_addr, imem_rdata, instr_d, pcplus4_d;
  logic        valid_d;
  logic [15:0] bubble_cnt;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  // Instruction memory contents: a hash of the address, with one J planted
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0010;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .flush_d    (flush_d),
    .pcsrc_d    (pcsrc_d),
    .pcbranch_d (pcbranch_d),
    .jump_d     (jump_d),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rdy   (imem_rdy),
    .instr_d    (instr_d),
    .pcplus4_d  (pcplus4_d),
    .valid_d    (valid_d),
    .bubble_cnt (bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt, npc;
    if (!reset) begin
      m_pc = RST_PC; m_instr = NOP; m_pcp4 = 0; m_valid = 0; m_cnt = 0;
      return;
    end
    redir = (pcsrc_d || jump_d) && m_valid && !stall_f;
    if (pcsrc_d) tgt = pcbranch_d & ~32'd3;
    else         tgt = (m_pcp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
    if (redir)                  npc = tgt;
    else if (stall_f || !imem_rdy) npc = m_pc;
    else                        npc = m_pc + 32'd4;
    if (!stall_f) begin
      if (redir || flush_d || !imem_rdy) begin
        m_instr = NOP; m_pcp4 = 0; m_valid = 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_instr = mem_word(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1;
      end
    end
    m_pc = npc;
  endtask

  // One clock: update model at the edge, compare all outputs 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("imem_addr",  imem_addr,  m_pc);
    check("instr_d",    instr_d,    m_instr);
    check("pcplus4_d",  pcplus4_d,  m_pcp4);
    check("valid_d",    {31'd0, valid_d}, {31'd0, m_valid});
    check("bubble_cnt", {16'd0, bubble_cnt}, m_cnt);
  endtask

  task automatic idle_inputs();
    stall_f = 0; flush_d = 0; pcsrc_d = 0; jump_d = 0; pcbranch_d = 0; imem_rdy = 1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s_pc, s_instr, s_pcp4;
    int unsigned s_cnt;
    idle_inputs();
    reset = 0;
    m_pc = 0; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_cnt = 0;

    // Reset state
    step(); step();
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_instr", instr_d,   NOP);
    check("rst_cnt",   {16'd0, bubble_cnt}, 32'd0);

    // Sequential fetch after release
    reset = 1;
    step(); check("seq_addr4", imem_addr, 32'h4); check("seq_instr0", instr_d, mem_word(32'h0));
    step(); check("seq_addr8", imem_addr, 32'h8); check("seq_instr4", instr_d, mem_word(32'h4));
    step();

    // Branch to 0x40: one bubble, count +1
    s_cnt = m_cnt;
    pcsrc_d = 1; pcbranch_d = 32'h40;
    step();
    check("br_addr",   imem_addr, 32'h40);
    check("br_bubble", {31'd0, valid_d}, 32'd0);
    check("br_cnt",    {16'd0, bubble_cnt}, s_cnt + 1);
    pcsrc_d = 0;
    step();
    check("br_target_instr", instr_d, mem_word(32'h40));

    // Reach the planted J at 0x10000004, then take the jump
    pcsrc_d = 1; pcbranch_d = 32'h1000_0006;
    step();
    check("br2_addr", imem_addr, 32'h1000_0004);
    pcsrc_d = 0;
    step();
    check("j_instr", instr_d,   32'h0800_0010);
    check("j_pcp4",  pcplus4_d, 32'h1000_0008);
    jump_d = 1;
    step();
    check("j_addr", imem_addr, 32'h1000_0040);
    jump_d = 0;
    step();

    // Stall with flush and branch pending: nothing moves
    s_pc = m_pc; s_instr = m_instr; s_pcp4 = m_pcp4; s_cnt = m_cnt;
    stall_f = 1; flush_d = 1; pcsrc_d = 1; pcbranch_d = 32'h80;
    for (int i = 0; i < 3; i++) step();
    check("stall_pc",    imem_addr, s_pc);
    check("stall_instr", instr_d,   s_instr);
    check("stall_pcp4",  pcplus4_d, s_pcp4);
    check("stall_cnt",   {16'd0, bubble_cnt}, s_cnt);
    idle_inputs();
    step();

    // Two wait states
    s_pc = m_pc; s_cnt = m_cnt;
    imem_rdy = 0;
    step(); step();
    check("wait_pc",  imem_addr, s_pc);
    check("wait_cnt", {16'd0, bubble_cnt}, s_cnt + 2);
    imem_rdy = 1;
    step();

    // PC wrap from 0xFFFFFFFC
    pcsrc_d = 1; pcbranch_d = 32'hFFFF_FFFC;
    step();
    pcsrc_d = 0;
    step();
    check("wrap_pc",   imem_addr, 32'h0);
    check("wrap_pcp4", pcplus4_d, 32'h0);

    // Counter saturation
    @(negedge clk);
    force dut.bubble_cnt_q = 16'hFFFE;
    #1 release dut.bubble_cnt_q;
    m_cnt = 16'hFFFE;
    flush_d = 1;
    step(); check("sat_ffff", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    step(); check("sat_hold", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    flush_d = 0;
    step(); step();

    // Reset during a redirect
    pcsrc_d = 1; pcbranch_d = 32'h200; reset = 0;
    step();
    check("rr_addr",  imem_addr, RST_PC);
    check("rr_valid", {31'd0, valid_d}, 32'd0);
    check("rr_cnt",   {16'd0, bubble_cnt}, 32'd0);
    check("rr_instr", instr_d, NOP);
    reset = 1; pcsrc_d = 0;
    step();
    check("rr_first_fetch", instr_d, mem_word(RST_PC));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) != 0);
      stall_f    = ($urandom_range(0, 4) == 0);
      flush_d    = ($urandom_range(0, 5) == 0);
      pcsrc_d    = ($urandom_range(0, 4) == 0);
      jump_d     = ($urandom_range(0, 5) == 0);
      imem_rdy   = ($urandom_range(0, 3) != 0);
      pcbranch_d = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, the PC loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000000, the instruction word used for bubbles.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port stall_f  input  1  hazard-unit request to hold PC and the IF/ID register.
REQ-006 SHALL have port flush_d  input  1  hazard-unit request to load a bubble into IF/ID.
REQ-007 SHALL have port pcsrc_d  input  1  branch taken, resolved in decode.
REQ-008 SHALL have port pcbranch_d  input  32  branch target from decode.
REQ-009 SHALL have port jump_d  input  1  decode holds a J instruction.
REQ-010 SHALL have port imem_addr  output  32  fetch PC presented to instruction memory.
REQ-011 SHALL have port imem_rdata  input  32  instruction word, combinational from imem_addr.
REQ-012 SHALL have port imem_rdy  input  1  imem_rdata valid this cycle; 0 is a wait state.
REQ-013 SHALL have port instr_d  output  32  IF/ID instruction register.
REQ-014 SHALL have port pcplus4_d  output  32  IF/ID PC+4 register.
REQ-015 SHALL have port valid_d  output  1  IF/ID contents are a real instruction, not a bubble.
REQ-016 SHALL have port bubble_cnt  output  16  count of bubbles inserted into IF/ID, saturating.

Function
REQ-017 imem_addr SHALL equal the PC register, combinationally, with no added latency.
REQ-018 Redirect SHALL be active when (pcsrc_d | jump_d) & valid_d & ~stall_f; pcsrc_d and jump_d are ignored otherwise.
REQ-019 Jump target SHALL be {pcplus4_d[31:28], instr_d[25:0], 2'b00}, computed from the IF/ID contents.
REQ-020 If both pcsrc_d and jump_d are high, the branch target SHALL win; target bits [1:0] SHALL be forced to 00.
REQ-021 The next-PC priority SHALL be: redirect -> target; else stall_f -> hold; else ~imem_rdy -> hold; else PC+4 (32-bit modulo, wrapping 0xFFFFFFFC to 0x00000000).
REQ-022 The IF/ID priority SHALL be: stall_f -> hold all three fields; else redirect or flush_d or ~imem_rdy -> bubble; else load {imem_rdata, PC+4, valid=1}.
REQ-023 A bubble SHALL set instr_d=NOP_INSTR, pcplus4_d=0 and valid_d=0.
REQ-024 stall_f SHALL override flush_d; stall_f with flush_d SHALL hold IF/ID unchanged.
REQ-025 A taken redirect SHALL cost exactly one bubble: the instruction fetched in the redirect cycle is discarded, and the target is fetched the next cycle.
REQ-026 bubble_cnt SHALL increment by 1 on each cycle IF/ID loads a bubble, SHALL saturate at 16'hFFFF, and SHALL not change while stall_f holds.
REQ-027 Stage latency SHALL be one cycle: the word at imem_addr in cycle N appears on instr_d in cycle N+1, given imem_rdy=1 and no stall, flush or redirect.

Reset
REQ-028 When reset=0 at a clock edge: PC=RESET_PC, instr_d=NOP_INSTR, pcplus4_d=0, valid_d=0, bubble_cnt=0, overriding all other inputs.
REQ-029 Reset asserted mid-redirect or mid-stall SHALL discard the pending action; the first fetch after release SHALL be RESET_PC.

Structure
REQ-030 The shared pipeline package SHALL hold the NOP_INSTR value, the J opcode/target field positions, and the IF/ID record type {instr, pcplus4, valid}.
REQ-031 The next-PC selection SHALL be a sub-module named pc_next_sel (combinational), instantiated once; the PC, IF/ID and counter registers stay in fetch_stage.

Verification
REQ-032 Reset release with RESET_PC=0, imem_rdy=1 -> imem_addr 0,4,8 on consecutive cycles; instr_d equals the word at the previous address, one cycle later.
REQ-033 pcsrc_d=1, pcbranch_d=0x40 with valid_d=1 -> next imem_addr=0x40, exactly one bubble on instr_d, bubble_cnt+1.
REQ-034 instr_d=0x08000010 (J), pcplus4_d=0x10000008, jump_d=1 -> next imem_addr=0x10000040.
REQ-035 stall_f=1 for 3 cycles with flush_d=1 and pcsrc_d=1 -> PC, IF/ID and bubble_cnt unchanged, redirect ignored.
REQ-036 imem_rdy=0 for 2 cycles -> PC held, two bubbles, bubble_cnt+2; PC=0xFFFFFFFC with rdy=1 -> next PC=0; bubble_cnt preloaded to 0xFFFF stays 0xFFFF.
REQ-037 reset=0 for one cycle during a redirect -> all outputs at reset values, next fetch at RESET_PC.
